pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning the redirect address for a misaligned target (used only with PC_MISALIGN_TRAP_EN).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-007 The block SHALL have port stall, input, 1 bit, meaning the pipeline cannot accept a new instruction this cycle.
REQ-008 The block SHALL have ports jump (input, 1 bit) and jump_target (input, N bits), meaning an unconditional redirect request and its target.
REQ-009 The block SHALL have ports branch_taken (input, 1 bit) and branch_target (input, N bits), meaning a resolved taken branch and its target.
REQ-010 The block SHALL have port fetch_req, output, 1 bit, meaning the fetch address on pc is valid and requested from instruction memory.
REQ-011 The block SHALL have port fetch_ack, input, 1 bit, meaning instruction memory accepted the request for pc this cycle.
REQ-012 The block SHALL have port pc, output, N bits, meaning the current fetch address.
REQ-013 The block SHALL have port misaligned, output, 1 bit, meaning a misaligned-target trap was taken (present only with PC_MISALIGN_TRAP_EN).

Function
REQ-014 The block SHALL implement states BOOT, REQ, HOLD.
REQ-015 BOOT: fetch_req=0; SHALL move to REQ on the next cycle with pc=RESET_VECTOR.
REQ-016 REQ: fetch_req=1. On fetch_ack with stall=0, pc SHALL update to the next PC in the same edge. On fetch_ack with stall=1, the block SHALL move to HOLD.
REQ-017 HOLD: fetch_req=0 and pc held. When stall=0, the block SHALL apply the next PC and return to REQ.
REQ-018 Next-PC priority SHALL be: pending redirect > jump > branch_taken > pc+4.
REQ-019 pc+4 SHALL wrap modulo 2^N (e.g. 32'hFFFF_FFFC -> 32'h0000_0000), with no flag.
REQ-020 A jump or branch_taken asserted in REQ without fetch_ack SHALL be latched into a one-entry pending-redirect register (higher priority wins if both are asserted), and pc SHALL stay stable until fetch_ack.
REQ-021 A newer redirect SHALL overwrite an older pending redirect.
REQ-022 The pending redirect SHALL be consumed and cleared on the next PC update.
REQ-023 pc SHALL never change while fetch_req=1 and fetch_ack=0.
REQ-024 A redirect in HOLD SHALL be latched as pending and applied when stall deasserts.

Reset
REQ-025 rst SHALL dominate all inputs.
REQ-026 On reset: state=BOOT, pc=RESET_VECTOR, fetch_req=0, pending cleared, misaligned=0.
REQ-027 Reset asserted mid-request SHALL abandon the outstanding fetch without waiting for fetch_ack.

Configuration
REQ-028 The macro PC_MISALIGN_TRAP_EN SHALL control misaligned-target handling.
REQ-029 With PC_MISALIGN_TRAP_EN defined, an applied target with bits [1:0]!=0 SHALL load TRAP_VECTOR instead and pulse misaligned high for exactly one cycle.
REQ-030 With PC_MISALIGN_TRAP_EN undefined, bits [1:0] of every target SHALL be forced to 0 and the misaligned port SHALL be absent.

Structure
REQ-031 Package philv_pc_pkg SHALL hold the state enum (BOOT/REQ/HOLD), the PC increment constant 4, and the default RESET_VECTOR/TRAP_VECTOR values.
REQ-032 The next-PC priority selection SHALL be a combinational sub-module named pc_next_mux.

Verification
REQ-033 Scenario: release rst, hold fetch_ack=1 -> pc = 0x0, 0x4, 0x8 on successive REQ cycles; fetch_req is 0 in the BOOT cycle.
REQ-034 Scenario: fetch_ack=0 for 3 cycles while branch_taken pulses with target 0x40 -> pc stays 0x8; after ack, pc=0x40.
REQ-035 Scenario: jump (target 0x80) and branch_taken (target 0x40) in the same acked cycle -> pc=0x80.
REQ-036 Scenario: stall=1 on an ack at pc=0x10 -> HOLD with fetch_req=0 and pc=0x10; stall=0 -> pc=0x14 and back in REQ.
REQ-037 Scenario: pc=0xFFFF_FFFC acked -> pc=0x0.
REQ-038 Scenario: jump target 0x42 with PC_MISALIGN_TRAP_EN -> pc=0x100 and one-cycle misaligned pulse; without the macro -> pc=0x40.

Source files
------------

// File: rtl/philv_pc_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// sequential increment and default vectors.
package philv_pc_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } pc_state_e;

   localparam int unsigned PC_INCR             = 4;
   localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_TRAP_VECTOR_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: pending redirect > jump > branch_taken > pc+4.
// Also presents the highest-priority fresh redirect for latching as pending.
module pc_next_mux
   import philv_pc_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] i_pc,
   input  logic         i_pend_vld,
   input  logic [N-1:0] i_pend_tgt,
   input  logic         i_jump,
   input  logic [N-1:0] i_jump_tgt,
   input  logic         i_branch,
   input  logic [N-1:0] i_branch_tgt,
   output logic [N-1:0] o_next_pc,
   output logic         o_is_tgt,
   output logic         o_new_vld,
   output logic [N-1:0] o_new_tgt
);

   always_comb begin
      o_new_vld = i_jump | i_branch;
      o_new_tgt = i_jump ? i_jump_tgt : i_branch_tgt;
      o_next_pc = i_pc + N'(PC_INCR);
      o_is_tgt  = 1'b0;
      if (i_pend_vld) begin
         o_next_pc = i_pend_tgt;
         o_is_tgt  = 1'b1;
      end else if (i_jump) begin
         o_next_pc = i_jump_tgt;
         o_is_tgt  = 1'b1;
      end else if (i_branch) begin
         o_next_pc = i_branch_tgt;
         o_is_tgt  = 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with one-entry pending redirect and stall handling.
// Macro PC_MISALIGN_TRAP_EN: misaligned targets trap to TRAP_VECTOR instead of being aligned.
//
//   state | meaning
//   BOOT  | first cycle out of reset, no fetch request
//   REQ   | fetch_req high, pc waits for fetch_ack
//   HOLD  | fetch accepted but pipeline stalled; pc held, no request
module pc_sequencer
   import philv_pc_pkg::*;
#(
   parameter int          N            = 32,
   parameter logic [N-1:0] RESET_VECTOR = N'(PC_RESET_VECTOR_DEF),
   parameter logic [N-1:0] TRAP_VECTOR  = N'(PC_TRAP_VECTOR_DEF)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         jump,
   input  logic [N-1:0] jump_target,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   output logic         fetch_req,
   input  logic         fetch_ack,
   output logic [N-1:0] pc
`ifdef PC_MISALIGN_TRAP_EN
   ,output logic        misaligned
`endif
);

   pc_state_e    r_state;
   pc_state_e    w_state_nxt;
   logic [N-1:0] r_pc;
   logic         r_pend_vld;
   logic [N-1:0] r_pend_tgt;

   logic         w_fetch_req;
   logic         w_pc_upd;
   logic         w_pend_ld;
   logic [N-1:0] w_sel_pc;
   logic         w_is_tgt;
   logic         w_new_vld;
   logic [N-1:0] w_new_tgt;
   logic [N-1:0] w_apply_pc;
   logic         w_trap;

   pc_next_mux #(.N(N)) u_next_mux (
      .i_pc         (r_pc),
      .i_pend_vld   (r_pend_vld),
      .i_pend_tgt   (r_pend_tgt),
      .i_jump       (jump),
      .i_jump_tgt   (jump_target),
      .i_branch     (branch_taken),
      .i_branch_tgt (branch_target),
      .o_next_pc    (w_sel_pc),
      .o_is_tgt     (w_is_tgt),
      .o_new_vld    (w_new_vld),
      .o_new_tgt    (w_new_tgt)
   );

`ifdef PC_MISALIGN_TRAP_EN
   assign w_trap     = w_is_tgt && (w_sel_pc[1:0] != 2'b00);
   assign w_apply_pc = w_trap ? TRAP_VECTOR : w_sel_pc;
`else
   logic w_unused_trap;
   assign w_unused_trap = ^TRAP_VECTOR;
   assign w_trap        = 1'b0;
   // only redirect targets are forced aligned; sequential pc stays as is
   assign w_apply_pc    = w_is_tgt ? {w_sel_pc[N-1:2], 2'b00} : w_sel_pc;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_fetch_req = 1'b0;
      w_pc_upd    = 1'b0;
      w_pend_ld   = 1'b0;
      unique case (r_state)
         BOOT: w_state_nxt = REQ;
         REQ: begin
            w_fetch_req = 1'b1;
            if (fetch_ack && !stall) begin
               w_pc_upd = 1'b1;
            end else begin
               // unacked or stalled: keep pc, remember any redirect
               w_pend_ld = 1'b1;
               if (fetch_ack) w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (!stall) begin
               w_pc_upd    = 1'b1;
               w_state_nxt = REQ;
            end else begin
               w_pend_ld = 1'b1;
            end
         end
         default: w_state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VECTOR;
         r_pend_vld <= 1'b0;
         r_pend_tgt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pc_upd) begin
            r_pc       <= w_apply_pc;
            r_pend_vld <= 1'b0;
         end else if (w_pend_ld && w_new_vld) begin
            r_pend_vld <= 1'b1;
            r_pend_tgt <= w_new_tgt;
         end
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   logic r_misaligned;
   always_ff @(posedge clk) begin
      if (rst) r_misaligned <= 1'b0;
      else     r_misaligned <= w_pc_upd && w_trap;
   end
   assign misaligned = r_misaligned;
`endif

   assign fetch_req = w_fetch_req;
   assign pc        = r_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default N=32 build, either macro setting).
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        jump;
   logic [31:0] jump_target;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        fetch_req;
   logic        fetch_ack;
   logic [31:0] pc;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .fetch_req     (fetch_req),
      .fetch_ack     (fetch_ack),
      .pc            (pc)
`ifdef PC_MISALIGN_TRAP_EN
      ,.misaligned   (misaligned)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0;
      branch_taken = 1'b0; branch_target = '0; fetch_ack = 1'b0;
      tick(); tick();
      check("rst_req", 32'(fetch_req), 32'd0);
      check("rst_pc", pc, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
      check("rst_mis", 32'(misaligned), 32'd0);
`endif

      // boot then sequential fetch
      rst = 1'b0; fetch_ack = 1'b1;
      check("boot_req", 32'(fetch_req), 32'd0);
      tick();
      check("seq0_req", 32'(fetch_req), 32'd1);
      check("seq0_pc", pc, 32'h0);
      tick(); check("seq1_pc", pc, 32'h4);
      tick(); check("seq2_pc", pc, 32'h8);

      // branch while unacked is held pending
      fetch_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
      tick(); check("wait0_pc", pc, 32'h8);
      branch_taken = 1'b0;
      tick(); check("wait1_pc", pc, 32'h8);
      tick(); check("wait2_pc", pc, 32'h8);
      check("wait_req", 32'(fetch_req), 32'd1);
      fetch_ack = 1'b1;
      tick(); check("pend_br_pc", pc, 32'h40);

      // jump beats branch in same cycle
      jump = 1'b1; jump_target = 32'h80; branch_taken = 1'b1; branch_target = 32'h40;
      tick(); check("jmp_prio_pc", pc, 32'h80);
      jump = 1'b0; branch_taken = 1'b0;

      // newer redirect overwrites pending one
      fetch_ack = 1'b0; jump = 1'b1; jump_target = 32'h200;
      tick();
      jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
      tick(); check("ovw_hold_pc", pc, 32'h80);
      branch_taken = 1'b0; fetch_ack = 1'b1;
      tick(); check("ovw_pc", pc, 32'h300);
      tick(); check("pend_clr_pc", pc, 32'h304);

      // stall on ack
      jump = 1'b1; jump_target = 32'h0C;
      tick(); jump = 1'b0;
      tick(); check("pre_stall_pc", pc, 32'h10);
      stall = 1'b1;
      tick();
      check("hold_req", 32'(fetch_req), 32'd0);
      check("hold_pc", pc, 32'h10);
      tick(); check("hold2_pc", pc, 32'h10);
      stall = 1'b0;
      tick();
      check("unstall_pc", pc, 32'h14);
      check("unstall_req", 32'(fetch_req), 32'd1);

      // redirect during HOLD applied on release
      stall = 1'b1;
      tick();
      jump = 1'b1; jump_target = 32'h500;
      tick(); jump = 1'b0;
      tick(); check("hold_jmp_pc", pc, 32'h14);
      stall = 1'b0;
      tick(); check("hold_rel_pc", pc, 32'h500);

      // reset mid-request abandons fetch and dominates inputs
      fetch_ack = 1'b0;
      tick(); check("pre_rst_pc", pc, 32'h500);
      rst = 1'b1; jump = 1'b1; jump_target = 32'h700; fetch_ack = 1'b1;
      tick();
      check("mid_rst_req", 32'(fetch_req), 32'd0);
      check("mid_rst_pc", pc, 32'h0);
      rst = 1'b0; jump = 1'b0;
      tick(); check("rst_boot_pc", pc, 32'h0);
      tick(); check("rst_seq_pc", pc, 32'h4);

      // wrap at top of address space
      jump = 1'b1; jump_target = 32'hFFFF_FFFC;
      tick(); jump = 1'b0;
      check("top_pc", pc, 32'hFFFF_FFFC);
      tick(); check("wrap_pc", pc, 32'h0);

      // misaligned target
      jump = 1'b1; jump_target = 32'h42;
      tick(); jump = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      check("trap_pc", pc, 32'h100);
      check("trap_mis", 32'(misaligned), 32'd1);
      tick();
      check("trap_mis_clr", 32'(misaligned), 32'd0);
      check("trap_next_pc", pc, 32'h104);
`else
      check("align_pc", pc, 32'h40);
      tick();
      check("align_next_pc", pc, 32'h44);
`endif

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
